// File: rtl/bsg_counter_overflow_multi.sv
//==============================================================================
// Module   : bsg_counter_overflow_multi
// Brief    : els_p independent up-counters with per-channel enable, clear,
//            programmable limit, wrap/saturate event pulse and sticky flag.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module bsg_counter_overflow_multi #(
  parameter int width_p    = 16,
  parameter int els_p      = 4,
  parameter int init_val_p = 0,
  parameter int max_val_p  = 999,
  parameter int saturate_p = 0,
  localparam int c_ID_W    = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [els_p-1:0]           en_i,
  input  logic [els_p-1:0]           clear_i,
  input  logic                       cfg_v_i,
  input  logic [c_ID_W-1:0]          cfg_id_i,
  input  logic [width_p-1:0]         cfg_limit_i,
  input  logic [els_p-1:0]           sticky_clr_i,
  output logic [els_p*width_p-1:0]   count_o,
  output logic [els_p*width_p-1:0]   limit_o,
  output logic [els_p-1:0]           overflow_o,
  output logic [els_p-1:0]           event_o,
  output logic [els_p-1:0]           sticky_o
);

  localparam logic [width_p-1:0] c_INIT = width_p'(init_val_p);
  localparam logic [width_p-1:0] c_MAX  = width_p'(max_val_p);
  localparam logic [width_p-1:0] c_ONE  = width_p'(1);

  for (genvar i = 0; i < els_p; i++) begin : g_ch
    logic [width_p-1:0] r_count;
    logic [width_p-1:0] r_limit;
    logic [width_p-1:0] w_count_nxt;
    logic               r_event;
    logic               r_sticky;
    logic               w_ovf;
    logic               w_hit;
    logic               w_cfg_we;

    // >= rather than == keeps a lowered limit from letting the count run away
    assign w_ovf    = (r_count >= r_limit);
    assign w_hit    = en_i[i] & w_ovf & ~clear_i[i];
    assign w_cfg_we = cfg_v_i && (cfg_id_i == c_ID_W'(i));

    always_comb begin
      w_count_nxt = r_count;
      if (clear_i[i]) begin
        w_count_nxt = c_INIT;
      end else if (en_i[i]) begin
        if (!w_ovf) begin
          w_count_nxt = r_count + c_ONE;
        end else if (saturate_p == 0) begin
          w_count_nxt = c_INIT;
        end
      end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        r_count  <= c_INIT;
        r_limit  <= c_MAX;
        r_event  <= 1'b0;
        r_sticky <= 1'b0;
      end else begin
        r_count  <= w_count_nxt;
        if (w_cfg_we) begin
          r_limit <= cfg_limit_i;
        end
        r_event  <= w_hit;
        // a new event outranks a same-cycle clear
        r_sticky <= w_hit | (r_sticky & ~sticky_clr_i[i]);
      end
    end

    assign count_o[i*width_p +: width_p] = r_count;
    assign limit_o[i*width_p +: width_p] = r_limit;
    assign overflow_o[i]                 = w_ovf;
    assign event_o[i]                    = r_event;
    assign sticky_o[i]                   = r_sticky;
  end

endmodule

`default_nettype wire

// File: doc/bsg_counter_overflow_multi.md
# bsg_counter_overflow_multi

Parametrised multi-channel successor to the single overflow counter. The block holds `els_p` independent up-counters. Each counter has its own enable, synchronous clear, and runtime-programmable limit, and is selected per instance to either wrap back to `init_val_p` or saturate at its limit. Each channel also provides a limit indicator, a registered wrap/saturate event pulse, and a sticky event flag for timeout, rate-divider and watchdog use.

## Interface
- `width_p`, default 16: counter and limit width in bits.
- `els_p`, default 4: number of independent channels.
- `init_val_p`, default 0: reset and reload value of every counter. Must be ≤ `max_val_p` and < 2^`width_p`.
- `max_val_p`, default 999: reset value of every channel's limit register. Must be < 2^`width_p`.
- `saturate_p`, default 0: 0 = wrap mode, 1 = saturate mode (applies to all channels).
- `clk_i` input 1: clock, rising edge.
- `reset_n_i` input 1: reset, asynchronous assert, active-low.
- `en_i` input `els_p`: per-channel count enable.
- `clear_i` input `els_p`: per-channel synchronous reload to `init_val_p`.
- `cfg_v_i` input 1: limit write strobe.
- `cfg_id_i` input `$clog2(els_p)` (min 1): channel index for the limit write. Index ≥ `els_p` is ignored.
- `cfg_limit_i` input `width_p`: new limit value.
- `sticky_clr_i` input `els_p`: per-channel sticky flag clear.
- `count_o` output `els_p*width_p`: counters; channel i in bits [i*width_p +: width_p].
- `limit_o` output `els_p*width_p`: current limit registers, same packing.
- `overflow_o` output `els_p`: combinational, `count ≥ limit` for channel i.
- `event_o` output `els_p`: registered one-cycle pulse per wrap/saturate event.
- `sticky_o` output `els_p`: registered sticky event flag.

## Operation
- Reset (`reset_n_i` = 0, asynchronous):
  - every count ← `init_val_p`;
  - every limit ← `max_val_p`;
  - `event_o` ← 0 and `sticky_o` ← 0.
  - `overflow_o` then follows from these values.
- Per channel i, per cycle, in priority order:
  1. `clear_i[i]`: count ← `init_val_p`. No event.
  2. `en_i[i]` and `overflow_o[i]` = 0: count ← count + 1, computed in `width_p` bits. Cannot carry out, because count < limit ≤ 2^`width_p` − 1.
  3. `en_i[i]` and `overflow_o[i]` = 1:
     - wrap mode: count ← `init_val_p`;
     - saturate mode: count holds;
     - either mode: an event fires.
  4. Otherwise count holds.
- The limit comparison is ≥, not ==. If the limit is lowered below the current count, that channel is immediately at limit:
  - next enabled cycle: wrap mode reloads, saturate mode holds;
  - the count never runs past the limit toward 2^`width_p`.
- Limit below `init_val_p`: `overflow_o` stays high after every reload. In wrap mode, every enabled cycle is an event.
- Limit write: when `cfg_v_i` is high, `limit[cfg_id_i]` ← `cfg_limit_i` at the clock edge.
  - The comparison in the write cycle uses the old limit.
  - The new limit applies from the next cycle.
  - The write does not touch the count.
- Event: `event_o[i]` is high in the cycle after the edge at which a case-3 update occurred; otherwise low.
  - Saturate mode: an event fires on every enabled cycle spent at the limit, so the pulse can repeat.
- Sticky: `sticky_o[i]` is set on an event and cleared by `sticky_clr_i[i]`. If both happen in the same cycle, set wins.
- Channels are fully independent. The only shared resource is the config write port.

## Timing
- `count_o`, `limit_o`, `event_o` and `sticky_o` are flops, updated at the rising edge.
- `overflow_o` is combinational from the count and limit flops, with no input-to-output path.
- Latencies:
  - enable to count change: 1 cycle;
  - wrap edge to `event_o`: the same edge, so the pulse is visible during the cycle in which the count first shows `init_val_p`;
  - limit write to effect: 1 cycle.
- A reset asserted mid-count reloads all state asynchronously. The first count after deassertion happens at the first edge with `en_i` high.

## Test plan
Test parameters: `width_p`=8, `els_p`=4, `init_val_p`=3, `max_val_p`=7.
- **Reset, then channel 0 wrap.** Reset, then hold `en_i[0]`. Required: count0 goes 3,4,5,6,7,3. `overflow_o[0]` is high only while count0=7. `event_o[0]` pulses once, in the cycle count0 returns to 3. `sticky_o[0]` = 1 afterwards. Channels 1–3 stay at 3.
- **Saturate.** With `saturate_p`=1, hold `en_i[1]` for 8 cycles. Required: count1 goes 3..7 then holds at 7. `event_o[1]` is high in each of the 4 cycles after the count first reaches 7.
- **Clear beats enable.** At count2=6, assert `clear_i[2]` and `en_i[2]` together. Required: count2=3 next cycle, no event.
- **Limit lowered below count.** At count3=6, write limit3=4. Required: in the write cycle `overflow_o[3]`=0 and count3 goes to 7. Next cycle `overflow_o[3]`=1. The next enabled edge reloads count3 to 3 with an event. After that, count3 wraps at 4.
- **Sticky set/clear collision.** Assert `sticky_clr_i[0]` in the same cycle as an event. Required: `sticky_o[0]` stays 1. Clearing in a later event-free cycle leaves it 0.
- **Mid-operation reset and bad config index.** Pulse `reset_n_i` low asynchronously between edges with counts at 5. Required: counts go to 3 and limits to 7 immediately. Separately, write with `cfg_id_i` ≥ `els_p` (use `els_p`=3). Required: no limit changes.
